// File: rtl/uart_word_tx_packer_pkg.sv
// Shared definitions for the UART word packer: default widths, header value and FSM states.
package uart_word_tx_packer_pkg;

    localparam int unsigned DBIT_DEF        = 8;
    localparam logic [7:0]  HEADER_BYTE_DEF = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    // Width of a byte index over n lanes; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_word_tx_packer_queue.sv
// Circular word FIFO with a registered occupancy count.
// The caller only pushes when not full or when popping in the same cycle.
module uart_word_queue
    import uart_word_tx_packer_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [W-1:0] mem_t [DEPTH];

    mem_t          mem_q, mem_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Next-state for storage, pointers and count; simultaneous push/pop leaves count unchanged.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_word_tx_packer.sv
// Word-to-byte packer feeding the UART TX byte FIFO: queues host words and
// emits them as paced, optionally header-prefixed byte writes.
module uart_word_tx_packer
    import uart_word_tx_packer_pkg::*;
#(
    parameter int unsigned     DBIT        = DBIT_DEF,
    parameter int unsigned     WORD_BYTES  = 2,
    parameter int unsigned     DEPTH       = 4,
    parameter bit              MSB_FIRST   = 1'b0,
    parameter bit              HEADER_EN   = 1'b0,
    parameter logic [DBIT-1:0] HEADER_BYTE = DBIT'(HEADER_BYTE_DEF)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_word,
    input  logic [DBIT*WORD_BYTES-1:0] word_in,
    output logic                       word_ready,
    input  logic                       clr_ovf,
    input  logic                       fifo_full,
    output logic [DBIT-1:0]            byte_out,
    output logic                       byte_wr,
    output logic                       busy,
    output logic                       overflow
);

    localparam int unsigned WW = DBIT * WORD_BYTES;
    localparam int unsigned IW = idx_width(WORD_BYTES);

    tx_state_e         state_q, state_d;
    logic [WW-1:0]     shift_q, shift_d;
    logic [IW-1:0]     byte_idx_q, byte_idx_d;
    logic              hdr_last_q, hdr_last_d;
    logic              byte_wr_q, byte_wr_d;
    logic [DBIT-1:0]   byte_out_q, byte_out_d;
    logic              overflow_q, overflow_d;

    logic              q_full, q_empty, q_push, q_pop;
    logic [WW-1:0]     q_head;
    logic [IW-1:0]     lane;
    logic [DBIT-1:0]   sel_byte;

    // A pop frees a slot in the same cycle, so a push into a full queue still lands then.
    assign q_pop      = (state_q == ST_IDLE) && !q_empty;
    assign q_push     = wr_word && (!q_full || q_pop);
    assign word_ready = !q_full;
    assign busy       = !q_empty || (state_q != ST_IDLE);
    assign byte_wr    = byte_wr_q;
    assign byte_out   = byte_out_q;
    assign overflow   = overflow_q;

    uart_word_queue #(
        .W     (WW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_data (word_in),
        .pop       (q_pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Select the current data byte from the held word according to byte order.
    always_comb begin
        lane     = MSB_FIRST ? (IW'(WORD_BYTES - 1) - byte_idx_q) : byte_idx_q;
        sel_byte = '0;
        for (int unsigned k = 0; k < WORD_BYTES; k++) begin
            if (lane == IW'(k)) begin
                sel_byte = shift_q[k*DBIT +: DBIT];
            end
        end
    end

    // Sticky overflow: a dropped push wins over a same-cycle clear.
    always_comb begin
        overflow_d = overflow_q;
        if (clr_ovf) begin
            overflow_d = 1'b0;
        end
        if (wr_word && !q_push) begin
            overflow_d = 1'b1;
        end
    end

    // Transmit FSM next-state and registered strobe/data; every strobe is followed by a GAP cycle.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        hdr_last_d = hdr_last_q;
        byte_wr_d  = 1'b0;
        byte_out_d = byte_out_q;
        case (state_q)
            ST_IDLE: begin
                if (q_pop) begin
                    shift_d    = q_head;
                    byte_idx_d = '0;
                    state_d    = HEADER_EN ? ST_HDR : ST_SEND;
                end
            end
            ST_HDR: begin
                if (!fifo_full) begin
                    byte_wr_d  = 1'b1;
                    byte_out_d = HEADER_BYTE;
                    hdr_last_d = 1'b1;
                    state_d    = ST_GAP;
                end
            end
            ST_SEND: begin
                if (!fifo_full) begin
                    byte_wr_d  = 1'b1;
                    byte_out_d = sel_byte;
                    hdr_last_d = 1'b0;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (hdr_last_q) begin
                    state_d = ST_SEND;
                end else if (byte_idx_q < IW'(WORD_BYTES - 1)) begin
                    byte_idx_d = byte_idx_q + IW'(1);
                    state_d    = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            byte_idx_q <= '0;
            hdr_last_q <= 1'b0;
            byte_wr_q  <= 1'b0;
            byte_out_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            hdr_last_q <= hdr_last_d;
            byte_wr_q  <= byte_wr_d;
            byte_out_q <= byte_out_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_word_tx_packer.sv
// Scoreboard bench for two packer configurations: A (2 bytes, LSB first, no header)
// and B (4 bytes, MSB first, header A5).
module tb_uart_word_tx_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Configuration A signals
    logic        rst_a, a_wr, a_clr, a_full;
    logic [15:0] a_word;
    logic        a_ready, a_bwr, a_busy, a_ovf;
    logic [7:0]  a_bout;

    // Configuration B signals
    logic        rst_b, b_wr, b_clr, b_full;
    logic [31:0] b_word;
    logic        b_ready, b_bwr, b_busy, b_ovf;
    logic [7:0]  b_bout;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    uart_word_tx_packer #(
        .DBIT(8), .WORD_BYTES(2), .DEPTH(4), .MSB_FIRST(1'b0), .HEADER_EN(1'b0), .HEADER_BYTE(8'hA5)
    ) dut_a (
        .clk(clk), .reset(rst_a), .wr_word(a_wr), .word_in(a_word), .word_ready(a_ready),
        .clr_ovf(a_clr), .fifo_full(a_full), .byte_out(a_bout), .byte_wr(a_bwr),
        .busy(a_busy), .overflow(a_ovf)
    );

    uart_word_tx_packer #(
        .DBIT(8), .WORD_BYTES(4), .DEPTH(4), .MSB_FIRST(1'b1), .HEADER_EN(1'b1), .HEADER_BYTE(8'hA5)
    ) dut_b (
        .clk(clk), .reset(rst_b), .wr_word(b_wr), .word_in(b_word), .word_ready(b_ready),
        .clr_ovf(b_clr), .fifo_full(b_full), .byte_out(b_bout), .byte_wr(b_bwr),
        .busy(b_busy), .overflow(b_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: a word becomes its bytes, least significant first.
    function automatic void model_a(input logic [15:0] w);
        for (int k = 0; k < 2; k++) exp_a.push_back(8'((w >> (8 * k)) & 16'hFF));
    endfunction

    // Reference: header, then most significant byte first.
    function automatic void model_b(input logic [31:0] w);
        exp_b.push_back(8'hA5);
        for (int k = 3; k >= 0; k--) exp_b.push_back(8'((w >> (8 * k)) & 32'hFF));
    endfunction

    // Monitors: pop and compare on every strobe; strobes must never be back to back.
    logic a_prev = 1'b0;
    logic b_prev = 1'b0;
    always @(negedge clk) begin
        if (a_bwr) begin
            if (exp_a.size() == 0) check("a_unexpected_byte", {24'd0, a_bout}, 32'hFFFF_FFFF);
            else check("a_byte", {24'd0, a_bout}, {24'd0, exp_a.pop_front()});
            if (a_prev) check("a_back_to_back", 1, 0);
        end
        a_prev = a_bwr;
    end
    always @(negedge clk) begin
        if (b_bwr) begin
            if (exp_b.size() == 0) check("b_unexpected_byte", {24'd0, b_bout}, 32'hFFFF_FFFF);
            else check("b_byte", {24'd0, b_bout}, {24'd0, exp_b.pop_front()});
            if (b_prev) check("b_back_to_back", 1, 0);
        end
        b_prev = b_bwr;
    end

    task automatic drain(input bit which, input string nm);
        int n = 0;
        while (n < 600 && (which ? (exp_b.size() != 0 || b_busy) : (exp_a.size() != 0 || a_busy))) begin
            @(negedge clk);
            n++;
        end
        check(nm, (n < 600) ? 1 : 0, 1);
    endtask

    task automatic wait_pulses_a(input int cnt, input string nm);
        int seen = 0;
        int n = 0;
        while (seen < cnt && n < 100) begin
            @(negedge clk);
            n++;
            if (a_bwr) seen++;
        end
        check(nm, seen, cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        logic [7:0]  held;
        rst_a = 1; a_wr = 0; a_clr = 0; a_full = 0; a_word = '0;
        rst_b = 1; b_wr = 0; b_clr = 0; b_full = 0; b_word = '0;
        repeat (3) @(negedge clk);
        // Reset state
        check("rst_a_ready", a_ready, 1);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_ovf", a_ovf, 0);
        check("rst_a_bwr", a_bwr, 0);
        check("rst_a_bout", a_bout, 0);
        check("rst_b_ready", b_ready, 1);
        check("rst_b_busy", b_busy, 0);
        rst_a = 0; rst_b = 0;
        @(negedge clk);

        // T1: BEEF -> EF, BE with fixed latency and pacing
        a_wr = 1; a_word = 16'hBEEF; model_a(16'hBEEF);
        @(negedge clk); a_wr = 0;                 // after edge N
        check("t1_n0_bwr", a_bwr, 0);
        @(negedge clk); check("t1_n1_bwr", a_bwr, 0);
        @(negedge clk); check("t1_n2_bwr", a_bwr, 1);
        @(negedge clk); check("t1_n3_bwr", a_bwr, 0);
        @(negedge clk); check("t1_n4_bwr", a_bwr, 1);
        check("t1_n4_busy", a_busy, 1);
        @(negedge clk); check("t1_n5_busy", a_busy, 0);

        // T2: header + MSB-first on config B
        b_wr = 1; b_word = 32'h01020304; model_b(32'h01020304);
        @(negedge clk); b_wr = 0;
        drain(1, "t2_drain");

        // T3: stalled output; FSM holds one word, queue holds DEPTH more, the next is dropped
        a_full = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) check("t3_ready_full", a_ready, 0);
            a_wr = 1; a_word = 16'($urandom);
            if (i < 5) model_a(a_word);
            @(negedge clk);
        end
        a_wr = 0;
        check("t3_ovf_set", a_ovf, 1);
        check("t3_no_strobe", a_bwr, 0);
        a_clr = 1; @(negedge clk); a_clr = 0;
        check("t3_ovf_clr", a_ovf, 0);
        a_full = 0;
        drain(0, "t3_drain");

        // T4: stall mid-word for 10 cycles
        w = 16'($urandom);
        a_wr = 1; a_word = w; model_a(w);
        @(negedge clk); a_wr = 0;
        wait_pulses_a(1, "t4_first");
        a_full = 1;
        held = a_bout;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_stall_bwr", a_bwr, 0);
            check("t4_stall_hold", a_bout, held);
        end
        a_full = 0;
        drain(0, "t4_drain");

        // T6: push into a full queue on the cycle of a pop, then overflow vs clr_ovf
        a_full = 1;
        for (int i = 0; i < 5; i++) begin
            a_wr = 1; a_word = 16'($urandom); model_a(a_word);
            @(negedge clk);
        end
        a_wr = 0;
        check("t6_full_ready", a_ready, 0);
        check("t6_full_ovf", a_ovf, 0);
        a_full = 0;
        wait_pulses_a(2, "t6_word_done");
        @(negedge clk);                            // FSM is IDLE with a full queue now
        a_wr = 1; a_word = 16'h6C6C; model_a(16'h6C6C);
        @(negedge clk);
        check("t6_pushpop_ovf", a_ovf, 0);
        check("t6_pushpop_ready", a_ready, 0);
        a_wr = 1; a_word = 16'hDEAD; a_clr = 1;    // dropped, set beats clear
        @(negedge clk);
        a_wr = 0; a_clr = 0;
        check("t6_set_over_clr", a_ovf, 1);
        drain(0, "t6_drain");

        // T5: reset after first byte drops the rest of the word
        a_wr = 1; a_word = 16'h1234; model_a(16'h1234);
        @(negedge clk); a_wr = 0;
        wait_pulses_a(1, "t5_first");
        rst_a = 1;
        @(negedge clk);
        exp_a.delete();
        @(negedge clk);
        rst_a = 0;
        check("t5_ready", a_ready, 1);
        check("t5_busy", a_busy, 0);
        check("t5_ovf", a_ovf, 0);
        repeat (8) @(negedge clk);
        a_wr = 1; a_word = 16'h5678; model_a(16'h5678);
        @(negedge clk); a_wr = 0;
        drain(0, "t5_drain");

        // Random traffic on both configurations with random back-pressure
        for (int i = 0; i < 300; i++) begin
            a_full = ($urandom_range(3) == 0);
            b_full = ($urandom_range(3) == 0);
            a_wr = 0; b_wr = 0;
            if (a_ready && $urandom_range(1) == 1) begin
                a_wr = 1; a_word = 16'($urandom); model_a(a_word);
            end
            if (b_ready && $urandom_range(2) == 0) begin
                b_wr = 1; b_word = $urandom; model_b(b_word);
            end
            @(negedge clk);
        end
        a_wr = 0; b_wr = 0; a_full = 0; b_full = 0;
        drain(0, "rand_a_drain");
        drain(1, "rand_b_drain");
        check("rand_a_ovf", a_ovf, 0);
        check("rand_b_ovf", b_ovf, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
